// File: rtl/hall_call_dispatcher.sv
// Latches shared hall calls and assigns each to the nearer of two cars.
// Ties alternate between cars. An assignment clears when its car stops at that floor.
module hall_call_dispatcher #(
    parameter int unsigned NUM_FLOORS = 6,
    parameter int unsigned POS_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_FLOORS-1:0]   hall_call,
    input  logic [2*POS_W-1:0]      half_elevatorPositions,
    input  logic [1:0]              door_open,
    output logic [2*NUM_FLOORS-1:0] FloorsRequested,
    output logic [NUM_FLOORS-1:0]   pending,
    output logic                    busy
);

    localparam int unsigned IDX_W   = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int unsigned DIST_W  = POS_W + 1;
    localparam int unsigned MAX_POS = 2 * (NUM_FLOORS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ASSIGN} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tie_pref_q, tie_pref_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] req_l_q, req_l_d;
    logic [NUM_FLOORS-1:0] req_r_q, req_r_d;
    logic                  busy_q, busy_d;

    logic [POS_W-1:0]      pos_l, pos_r, sat_l, sat_r;
    logic [DIST_W-1:0]     tgt, dist_l, dist_r;
    logic [NUM_FLOORS-1:0] stop_l, stop_r, sel_vec;
    logic                  tie, pick_left, pend_at_idx, idx_last;

    // Distance of each car to the floor under the scan pointer, and stop masks
    always_comb begin
        pos_l  = half_elevatorPositions[2*POS_W-1:POS_W];
        pos_r  = half_elevatorPositions[POS_W-1:0];
        sat_l  = (pos_l > POS_W'(MAX_POS)) ? POS_W'(MAX_POS) : pos_l;
        sat_r  = (pos_r > POS_W'(MAX_POS)) ? POS_W'(MAX_POS) : pos_r;
        tgt    = DIST_W'({idx_q, 1'b0});
        dist_l = (DIST_W'(sat_l) >= tgt) ? DIST_W'(sat_l) - tgt : tgt - DIST_W'(sat_l);
        dist_r = (DIST_W'(sat_r) >= tgt) ? DIST_W'(sat_r) - tgt : tgt - DIST_W'(sat_r);
        tie       = (dist_l == dist_r);
        pick_left = tie ? tie_pref_q : (dist_l < dist_r);
        sel_vec     = NUM_FLOORS'(1) << idx_q;
        pend_at_idx = |(pending_q & sel_vec);
        idx_last    = (idx_q == LAST_IDX);
        stop_l = '0;
        stop_r = '0;
        // Odd half-floor positions are between floors and never clear anything
        for (int f = 0; f < NUM_FLOORS; f++) begin
            stop_l[f] = door_open[1] && !pos_l[0] && (pos_l[POS_W-1:1] == (POS_W-1)'(f));
            stop_r[f] = door_open[0] && !pos_r[0] && (pos_r[POS_W-1:1] == (POS_W-1)'(f));
        end
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tie_pref_q <= 1'b0;
            pending_q  <= '0;
            req_l_q    <= '0;
            req_r_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tie_pref_q <= tie_pref_d;
            pending_q  <= pending_d;
            req_l_q    <= req_l_d;
            req_r_q    <= req_r_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|pending_q) state_d = ST_SCAN;
            ST_SCAN: begin
                if (pend_at_idx)   state_d = ST_ASSIGN;
                else if (idx_last) state_d = ST_IDLE;
            end
            ST_ASSIGN: state_d = idx_last ? ST_IDLE : ST_SCAN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Latch, assignment and service-clear logic
    always_comb begin
        idx_d      = idx_q;
        tie_pref_d = tie_pref_q;
        req_l_d    = req_l_q;
        req_r_d    = req_r_q;
        pending_d  = pending_q | (hall_call & ~(req_l_q | req_r_q));
        case (state_q)
            ST_IDLE: idx_d = '0;
            ST_SCAN: begin
                if (!pend_at_idx) idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
            end
            ST_ASSIGN: begin
                pending_d = pending_d & ~sel_vec;
                if (pick_left) req_l_d = req_l_d | sel_vec;
                else           req_r_d = req_r_d | sel_vec;
                if (tie) tie_pref_d = ~tie_pref_q;
                idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
            end
            default: idx_d = '0;
        endcase
        // A stopped car clears its own floor; this also covers a call served on arrival
        req_l_d = req_l_d & ~stop_l;
        req_r_d = req_r_d & ~stop_r;
        busy_d  = (state_d != ST_IDLE);
    end

    assign FloorsRequested = {req_l_q, req_r_q};
    assign pending         = pending_q;
    assign busy            = busy_q;

endmodule
